ball_physics_engine: RTL and testbench

//  Multi-ball successor of the single-ball positioner. Per-ball state: fixed-point position, velocity.

---
 rtl/ball_phys_pkg.sv | 34 +++
 rtl/ball_physics_engine_axis.sv | 64 ++++++
 rtl/ball_physics_engine.sv | 205 ++++++++++++++++++++
 tb/tb_ball_physics_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_phys_pkg.sv
// Shared widths, fixed-point types, FSM encoding and velocity saturation for the ball physics engine.
// Positions and velocities are signed Q.FRAC_BITS; positions are carried at full intermediate width.
package ball_phys_pkg;

    localparam int unsigned FRAC_BITS = 4;
    localparam int unsigned POS_W     = 10 + FRAC_BITS;
    localparam int unsigned WIDE_W    = POS_W + 2;
    localparam int unsigned VEL_W     = 10;
    localparam int unsigned ACC_W     = 8;
    localparam int unsigned PIX_W     = 10;

    typedef logic signed [WIDE_W-1:0] pos_t;
    typedef logic signed [VEL_W-1:0]  vel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SWAP = 2'd2
    } fsm_state_e;

    // Clamp a wide signed velocity sum to +-vmax.
    function automatic vel_t sat_vel(input pos_t v, input pos_t vmax);
        vel_t r;
        if (v > vmax) begin
            r = vel_t'(vmax);
        end else if (v < -vmax) begin
            r = vel_t'(-vmax);
        end else begin
            r = vel_t'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/ball_physics_engine_axis.sv
// Combinational single-axis update: saturate velocity, integrate, clamp to walls with damped bounce.
// Optional friction term enabled by defining BALL_PHYS_FRICTION_EN.
module ball_axis_integrator
    import ball_phys_pkg::*;
#(
    parameter int unsigned VEL_MAX    = 255,
    parameter int unsigned DAMP_SHIFT = 2
) (
    input  logic [ACC_W-1:0]  accel_i,
    input  logic [WIDE_W-1:0] pos_i,
    input  logic [VEL_W-1:0]  vel_i,
    input  logic [WIDE_W-1:0] lo_i,
    input  logic [WIDE_W-1:0] hi_i,
    output logic [WIDE_W-1:0] pos_o,
    output logic [VEL_W-1:0]  vel_o
);

    pos_t p_cur;
    pos_t lo;
    pos_t hi;
    pos_t v_sum;
    pos_t p_sum;
    vel_t v_cur;
    vel_t v_sat;
    vel_t v_fin;
    vel_t v_bnc;
`ifdef BALL_PHYS_FRICTION_EN
    vel_t v_mag;
    vel_t v_fric;
`endif

    always_comb begin
        p_cur = $signed(pos_i);
        v_cur = $signed(vel_i);
        lo    = $signed(lo_i);
        hi    = $signed(hi_i);
        v_sum = pos_t'(v_cur) + pos_t'($signed(accel_i));
        v_sat = sat_vel(v_sum, pos_t'(VEL_MAX));
`ifdef BALL_PHYS_FRICTION_EN
        // Friction magnitude rounds toward zero; small coasting velocities die out.
        v_mag  = v_sat[VEL_W-1] ? -v_sat : v_sat;
        v_fric = v_mag >>> 5;
        v_fin  = v_sat[VEL_W-1] ? (v_sat + v_fric) : (v_sat - v_fric);
        if ((accel_i == '0) && (v_mag < vel_t'(32))) begin
            v_fin = '0;
        end
`else
        v_fin = v_sat;
`endif
        p_sum = p_cur + pos_t'(v_fin);
        v_bnc = -(v_fin - (v_fin >>> DAMP_SHIFT));

        pos_o = p_sum;
        vel_o = v_fin;
        if (p_sum < lo) begin
            pos_o = lo;
            vel_o = v_bnc;
        end else if (p_sum > hi) begin
            pos_o = hi;
            vel_o = v_bnc;
        end
    end

endmodule

// File: rtl/ball_physics_engine.sv
// Multi-ball physics engine: one ball per cycle per frame tick, double-buffered pixel outputs.
// Define BALL_PHYS_FRICTION_EN to add a velocity friction term in the axis integrator.
module ball_physics_engine
    import ball_phys_pkg::*;
#(
    parameter int unsigned NUM_BALLS     = 4,
    parameter int unsigned SCREEN_WIDTH  = 800,
    parameter int unsigned SCREEN_HEIGHT = 600,
    parameter int unsigned BALL_RADIUS   = 20,
    parameter int unsigned VEL_MAX       = 255,
    parameter int unsigned DAMP_SHIFT    = 2
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         i_tick,
    input  logic                         i_recenter,
    input  logic [NUM_BALLS*ACC_W-1:0]   i_accel_x,
    input  logic [NUM_BALLS*ACC_W-1:0]   i_accel_y,
    output logic [NUM_BALLS*PIX_W-1:0]   o_ball_x,
    output logic [NUM_BALLS*PIX_W-1:0]   o_ball_y,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic                         o_overrun
);

    localparam int unsigned KW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

    localparam pos_t CX   = pos_t'((SCREEN_WIDTH / 2) << FRAC_BITS);
    localparam pos_t CY   = pos_t'((SCREEN_HEIGHT / 2) << FRAC_BITS);
    localparam pos_t LO_X = pos_t'(BALL_RADIUS << FRAC_BITS);
    localparam pos_t LO_Y = pos_t'(BALL_RADIUS << FRAC_BITS);
    localparam pos_t HI_X = pos_t'((SCREEN_WIDTH - BALL_RADIUS) << FRAC_BITS);
    localparam pos_t HI_Y = pos_t'((SCREEN_HEIGHT - BALL_RADIUS) << FRAC_BITS);

    localparam logic [PIX_W-1:0] CX_PIX = PIX_W'(SCREEN_WIDTH / 2);
    localparam logic [PIX_W-1:0] CY_PIX = PIX_W'(SCREEN_HEIGHT / 2);

    fsm_state_e                    state_q, state_d;
    logic [KW-1:0]                 k_q, k_d;
    pos_t                          px_q [NUM_BALLS];
    pos_t                          px_d [NUM_BALLS];
    pos_t                          py_q [NUM_BALLS];
    pos_t                          py_d [NUM_BALLS];
    vel_t                          vx_q [NUM_BALLS];
    vel_t                          vx_d [NUM_BALLS];
    vel_t                          vy_q [NUM_BALLS];
    vel_t                          vy_d [NUM_BALLS];
    logic [NUM_BALLS*ACC_W-1:0]    ax_q, ax_d;
    logic [NUM_BALLS*ACC_W-1:0]    ay_q, ay_d;
    logic [NUM_BALLS*PIX_W-1:0]    ox_q, ox_d;
    logic [NUM_BALLS*PIX_W-1:0]    oy_q, oy_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          ovr_q, ovr_d;
    logic                          pend_q, pend_d;

    logic [WIDE_W-1:0]             px_new;
    logic [WIDE_W-1:0]             py_new;
    logic [VEL_W-1:0]              vx_new;
    logic [VEL_W-1:0]              vy_new;

    // Shared integrators operate on the ball selected by k_q.
    ball_axis_integrator #(
        .VEL_MAX    (VEL_MAX),
        .DAMP_SHIFT (DAMP_SHIFT)
    ) u_axis_x (
        .accel_i (ax_q[ACC_W*k_q +: ACC_W]),
        .pos_i   (px_q[k_q]),
        .vel_i   (vx_q[k_q]),
        .lo_i    (LO_X),
        .hi_i    (HI_X),
        .pos_o   (px_new),
        .vel_o   (vx_new)
    );

    ball_axis_integrator #(
        .VEL_MAX    (VEL_MAX),
        .DAMP_SHIFT (DAMP_SHIFT)
    ) u_axis_y (
        .accel_i (ay_q[ACC_W*k_q +: ACC_W]),
        .pos_i   (py_q[k_q]),
        .vel_i   (vy_q[k_q]),
        .lo_i    (LO_Y),
        .hi_i    (HI_Y),
        .pos_o   (py_new),
        .vel_o   (vy_new)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        px_d    = px_q;
        py_d    = py_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        pend_d  = pend_q;

        unique case (state_q)
            ST_IDLE: begin
                // Recenter has priority; a coincident tick is simply dropped.
                if (pend_q || i_recenter) begin
                    pend_d = 1'b0;
                    for (int b = 0; b < NUM_BALLS; b++) begin
                        px_d[b] = CX;
                        py_d[b] = CY;
                        vx_d[b] = '0;
                        vy_d[b] = '0;
                    end
                    ox_d = {NUM_BALLS{CX_PIX}};
                    oy_d = {NUM_BALLS{CY_PIX}};
                end else if (i_tick) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    ax_d    = i_accel_x;
                    ay_d    = i_accel_y;
                end
            end
            ST_RUN: begin
                px_d[k_q] = $signed(px_new);
                py_d[k_q] = $signed(py_new);
                vx_d[k_q] = $signed(vx_new);
                vy_d[k_q] = $signed(vy_new);
                if (i_tick) begin
                    ovr_d = 1'b1;
                end
                if (i_recenter) begin
                    pend_d = 1'b1;
                end
                if (k_q == KW'(NUM_BALLS - 1)) begin
                    state_d = ST_SWAP;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_SWAP: begin
                for (int b = 0; b < NUM_BALLS; b++) begin
                    ox_d[PIX_W*b +: PIX_W] = PIX_W'(px_q[b] >>> FRAC_BITS);
                    oy_d[PIX_W*b +: PIX_W] = PIX_W'(py_q[b] >>> FRAC_BITS);
                end
                if (i_tick) begin
                    ovr_d = 1'b1;
                end
                if (i_recenter) begin
                    pend_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            for (int b = 0; b < NUM_BALLS; b++) begin
                px_q[b] <= CX;
                py_q[b] <= CY;
                vx_q[b] <= '0;
                vy_q[b] <= '0;
            end
            ax_q    <= '0;
            ay_q    <= '0;
            ox_q    <= {NUM_BALLS{CX_PIX}};
            oy_q    <= {NUM_BALLS{CY_PIX}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            px_q    <= px_d;
            py_q    <= py_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
        end
    end

    assign o_ball_x     = ox_q;
    assign o_ball_y     = oy_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_ball_physics_engine.sv
// Scoreboard bench for ball_physics_engine: a behavioural model predicts each frame's pixels on tick.
module tb_ball_physics_engine;

    localparam int NB = 4;
    localparam int W  = 800;
    localparam int H  = 600;
    localparam int R  = 20;
    localparam int F  = 16;

    logic              clk;
    logic              arst_n;
    logic              i_tick;
    logic              i_recenter;
    logic [NB*8-1:0]   i_accel_x;
    logic [NB*8-1:0]   i_accel_y;
    logic [NB*10-1:0]  o_ball_x;
    logic [NB*10-1:0]  o_ball_y;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_overrun;

    ball_physics_engine dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_tick       (i_tick),
        .i_recenter   (i_recenter),
        .i_accel_x    (i_accel_x),
        .i_accel_y    (i_accel_y),
        .o_ball_x     (o_ball_x),
        .o_ball_y     (o_ball_y),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_overrun    (o_overrun)
    );

    typedef struct {
        logic [NB*10-1:0] x;
        logic [NB*10-1:0] y;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   mpx[NB];
    int   mpy[NB];
    int   mvx[NB];
    int   mvy[NB];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int bounce(input int v);
        int fl;
        fl = (v >= 0) ? (v / 4) : -((-v + 3) / 4);
        return -(v - fl);
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            mpx[b] = (W / 2) * F;
            mpy[b] = (H / 2) * F;
            mvx[b] = 0;
            mvy[b] = 0;
        end
    endfunction

    function automatic void axis(input int a, input int p, input int v, input int dim,
                                 output int p_o, output int v_o);
        int v1, p1, lo, hi;
        lo = R * F;
        hi = (dim - R) * F;
        v1 = v + a;
        if (v1 > 255)  v1 = 255;
        if (v1 < -255) v1 = -255;
        p1 = p + v1;
        if (p1 < lo) begin
            p_o = lo; v_o = bounce(v1);
        end else if (p1 > hi) begin
            p_o = hi; v_o = bounce(v1);
        end else begin
            p_o = p1; v_o = v1;
        end
    endfunction

    function automatic exp_t model_step(input int due);
        exp_t e;
        int   np, nv;
        logic [7:0] a;
        for (int b = 0; b < NB; b++) begin
            a = i_accel_x[8*b +: 8];
            axis(int'($signed(a)), mpx[b], mvx[b], W, np, nv);
            mpx[b] = np; mvx[b] = nv;
            a = i_accel_y[8*b +: 8];
            axis(int'($signed(a)), mpy[b], mvy[b], H, np, nv);
            mpy[b] = np; mvy[b] = nv;
            e.x[10*b +: 10] = 10'(mpx[b] / F);
            e.y[10*b +: 10] = 10'(mpy[b] / F);
        end
        e.due = due;
        return e;
    endfunction

    // Scoreboard consumer: every frame_done pops one prediction.
    always @(negedge clk) begin
        if (arst_n && o_frame_done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", int'(o_frame_done), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("done_latency", cyc, e.due);
                for (int b = 0; b < NB; b++) begin
                    check_eq($sformatf("frame_x%0d", b), int'(o_ball_x[10*b +: 10]), int'(e.x[10*b +: 10]));
                    check_eq($sformatf("frame_y%0d", b), int'(o_ball_y[10*b +: 10]), int'(e.y[10*b +: 10]));
                end
            end
        end
    end

    task automatic do_tick();
        @(negedge clk);
        i_tick = 1'b1;
        sb.push_back(model_step(cyc + NB + 2));
        @(negedge clk);
        i_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || o_busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_queue", sb.size(), 0);
        check_eq("drain_busy", int'(o_busy), 0);
    endtask

    task automatic check_centre(input string tag);
        for (int b = 0; b < NB; b++) begin
            check_eq({tag, "_x"}, int'(o_ball_x[10*b +: 10]), W / 2);
            check_eq({tag, "_y"}, int'(o_ball_y[10*b +: 10]), H / 2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1exp[3];
        int hit1;
        p1exp = '{401, 403, 406};
        hit1  = 0;
        arst_n = 1'b0; i_tick = 1'b0; i_recenter = 1'b0;
        i_accel_x = '0; i_accel_y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check_centre("rst");
        check_eq("rst_busy", int'(o_busy), 0);
        check_eq("rst_overrun", int'(o_overrun), 0);
        check_eq("rst_done", int'(o_frame_done), 0);

        // Constant push on ball 0.
        i_accel_x[7:0] = 8'd16;
        for (int f = 0; f < 3; f++) begin
            do_tick();
            check_eq("busy_in_pass", int'(o_busy), 1);
            wait_idle();
            check_eq("b0_x_step", int'(o_ball_x[9:0]), p1exp[f]);
        end

        // Saturation, wall bounces and random accelerations.
        i_accel_x[7:0]   = 8'd0;
        i_accel_x[15:8]  = 8'h80;
        i_accel_y[23:16] = 8'd100;
        for (int f = 0; f < 30; f++) begin
            i_accel_x[31:24] = 8'($urandom);
            i_accel_y[31:24] = 8'($urandom);
            do_tick();
            wait_idle();
            if (int'(o_ball_x[19:10]) == R) hit1 = 1;
        end
        check_eq("b1_hit_left_wall", hit1, 1);

        // Recenter during a pass: pass completes, then everything recentres.
        do_tick();
        @(negedge clk);
        i_recenter = 1'b1;
        @(negedge clk);
        i_recenter = 1'b0;
        wait_idle();
        @(negedge clk);
        check_centre("recenter_mid");
        check_eq("recenter_no_overrun", int'(o_overrun), 0);
        model_reset();
        i_accel_x = '0; i_accel_y = '0;
        do_tick();
        wait_idle();

        // Tick and recenter together in idle: no pass.
        i_accel_x[7:0] = 8'd40;
        do_tick(); wait_idle();
        do_tick(); wait_idle();
        @(negedge clk);
        i_tick = 1'b1; i_recenter = 1'b1;
        @(negedge clk);
        i_tick = 1'b0; i_recenter = 1'b0;
        model_reset();
        check_eq("tick_rc_busy", int'(o_busy), 0);
        check_centre("tick_rc");
        repeat (NB + 4) @(negedge clk);
        check_eq("tick_rc_busy_late", int'(o_busy), 0);
        check_eq("tick_rc_overrun", int'(o_overrun), 0);

        // Overrun: second tick two cycles after the first.
        do_tick();
        @(negedge clk);
        i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        wait_idle();
        repeat (NB + 4) @(negedge clk);
        check_eq("overrun_set", int'(o_overrun), 1);
        i_accel_y[7:0] = 8'hE0;
        do_tick(); wait_idle();
        do_tick(); wait_idle();
        check_eq("overrun_sticky", int'(o_overrun), 1);

        // Reset in the middle of a pass.
        do_tick();
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        sb.delete();
        model_reset();
        check_centre("rst_mid");
        check_eq("rst_mid_busy", int'(o_busy), 0);
        check_eq("rst_mid_overrun", int'(o_overrun), 0);
        check_eq("rst_mid_done", int'(o_frame_done), 0);
        repeat (NB + 6) @(negedge clk);
        i_accel_x = '0; i_accel_y = '0;
        do_tick(); wait_idle();
        check_centre("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
